mesh_job_scheduler: RTL and testbench

Job-level sequencer in front of the systolic mesh top level (FSM controller plus 2-D MAC mesh). It accepts a weight stream and an input-vector stream over valid/ready handshakes. It drives the mesh preload port word by word, then pulses `start` with a held input vector. After a fixed latency it captures `result_flat` into a result register that downstream logic drains with valid/ready. It replaces ad-hoc bench/host sequencing of `preload_*`, `start` and result sampling.

---
 rtl/mesh_job_scheduler.sv | 237 +++++++++++++++++++++++
 tb/tb_mesh_job_scheduler.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mesh_job_scheduler.sv
// mesh_job_scheduler
// Job-level sequencer for the systolic mesh. It streams a weight matrix into
// the mesh preload port, launches a run with a held input vector, waits a
// fixed latency and captures the mesh result. Downstream logic drains the
// captured result over valid/ready. Loaded weights stay valid in IDLE, so a
// fresh input vector can reuse them without a reload.
module mesh_job_scheduler #(
    parameter int DW         = 8,
    parameter int ROWS       = 1,
    parameter int COLS       = 1,
    parameter int ROW_W      = 1,
    parameter int COL_W      = 2,
    parameter int ACC_W      = 16,
    parameter int CYCLE_W    = 5,
    parameter int LAT_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    // weight stream
    input  logic                     w_valid,
    output logic                     w_ready,
    input  logic [DW-1:0]            w_data,
    input  logic                     w_last,
    // input-vector stream
    input  logic                     x_valid,
    output logic                     x_ready,
    input  logic [COLS*DW-1:0]       x_data,
    // result stream
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [ROWS*ACC_W-1:0]    res_data,
    // mesh side
    output logic                     preload_valid,
    output logic [ROW_W+COL_W-1:0]   preload_addr,
    output logic [DW-1:0]            preload_data,
    output logic                     start,
    output logic [COLS*DW-1:0]       x_vector_flat,
    input  logic [ROWS*ACC_W-1:0]    result_flat,
    // status
    output logic                     busy,
    output logic                     err_len
);

    localparam int N     = ROWS * COLS;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(N - 1);
    localparam logic [COL_W-1:0]   COL_LAST = COL_W'(COLS - 1);
    localparam logic [CYCLE_W-1:0] LAT_VAL  = CYCLE_W'(LAT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_WAITX  = 3'd2,
        S_RUN    = 3'd3,
        S_RESULT = 3'd4
    } state_t;

    state_t state_reg, state_next;

    // load bookkeeping
    logic [ROW_W-1:0]   row_reg;
    logic [COL_W-1:0]   col_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic               wv_reg;
    logic [CYCLE_W-1:0] lat_cnt_reg;

    // per-column copy of the held input vector
    logic [DW-1:0]      x_lane_reg [COLS];

    // position of the word currently offered and the position after it
    logic [ROW_W-1:0]   cur_row, row_next;
    logic [COL_W-1:0]   cur_col, col_next;
    logic [IDX_W-1:0]   cur_idx, idx_next;
    logic               is_last;

    // control strobes from the FSM
    logic               accept_w;
    logic               accept_x;
    logic               capture;
    logic               release_res;

    // Word 0 of every load starts at {0,0}; later words use the running indices.
    always_comb begin
        cur_row  = row_reg;
        cur_col  = col_reg;
        cur_idx  = idx_reg;
        if (state_reg == S_IDLE) begin
            cur_row = '0;
            cur_col = '0;
            cur_idx = '0;
        end
        is_last  = (cur_idx == LAST_IDX);
        idx_next = cur_idx + IDX_W'(1);
        col_next = cur_col + COL_W'(1);
        row_next = cur_row;
        if (cur_col == COL_LAST) begin
            col_next = '0;
            row_next = cur_row + ROW_W'(1);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic, handshake readies and control strobes.
    always_comb begin
        state_next  = state_reg;
        accept_w    = 1'b0;
        accept_x    = 1'b0;
        capture     = 1'b0;
        release_res = 1'b0;
        w_ready     = (state_reg == S_IDLE) || (state_reg == S_LOAD);
        // in IDLE a pending weight word has priority, so x is held off
        x_ready     = (state_reg == S_WAITX) ||
                      ((state_reg == S_IDLE) && wv_reg && !w_valid);
        busy        = (state_reg != S_IDLE);
        case (state_reg)
            S_IDLE: begin
                if (w_valid) begin
                    accept_w   = 1'b1;
                    state_next = is_last ? S_WAITX : S_LOAD;
                end else if (x_valid && wv_reg) begin
                    accept_x   = 1'b1;
                    state_next = S_RUN;
                end
            end
            S_LOAD: begin
                if (w_valid) begin
                    accept_w = 1'b1;
                    // the word count ends a load, never w_last
                    if (is_last) begin
                        state_next = S_WAITX;
                    end
                end
            end
            S_WAITX: begin
                if (x_valid) begin
                    accept_x   = 1'b1;
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (lat_cnt_reg == LAT_VAL) begin
                    capture    = 1'b1;
                    state_next = S_RESULT;
                end
            end
            S_RESULT: begin
                if (res_ready) begin
                    release_res = 1'b1;
                    state_next  = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Weight load: index tracking, registered preload write and length check.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_reg       <= '0;
            col_reg       <= '0;
            idx_reg       <= '0;
            wv_reg        <= 1'b0;
            preload_valid <= 1'b0;
            preload_addr  <= '0;
            preload_data  <= '0;
            err_len       <= 1'b0;
        end else begin
            preload_valid <= accept_w;
            err_len       <= accept_w && (is_last != w_last);
            if (accept_w) begin
                preload_addr <= {cur_row, cur_col};
                preload_data <= w_data;
                row_reg      <= row_next;
                col_reg      <= col_next;
                idx_reg      <= idx_next;
                // first word invalidates old weights, last word validates new ones
                wv_reg       <= is_last;
            end
        end
    end

    // Run launch and latency counter; count 0 is the start cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start       <= 1'b0;
            lat_cnt_reg <= '0;
        end else begin
            start <= accept_x;
            if (accept_x) begin
                lat_cnt_reg <= '0;
            end else if (state_reg == S_RUN) begin
                lat_cnt_reg <= lat_cnt_reg + CYCLE_W'(1);
            end
        end
    end

    // Input vector lanes: loaded only on an x handshake, held otherwise.
    generate
        for (genvar gi = 0; gi < COLS; gi++) begin : g_x_lane
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    x_lane_reg[gi] <= '0;
                end else if (accept_x) begin
                    x_lane_reg[gi] <= x_data[gi*DW +: DW];
                end
            end
            assign x_vector_flat[gi*DW +: DW] = x_lane_reg[gi];
        end
    endgenerate

    // Result capture and valid/ready hold until drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            if (capture) begin
                res_valid <= 1'b1;
                res_data  <= result_flat;
            end else if (release_res) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mesh_job_scheduler.sv
// Directed bench for mesh_job_scheduler with a 2x2 mesh and 4-cycle latency.
module tb_mesh_job_scheduler;

    localparam int DW = 8, ROWS = 2, COLS = 2, ROW_W = 1, COL_W = 2;
    localparam int ACC_W = 16, CYCLE_W = 5, LAT_CYCLES = 4;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   w_valid = 1'b0;
    logic                   w_ready;
    logic [DW-1:0]          w_data = '0;
    logic                   w_last = 1'b0;
    logic                   x_valid = 1'b0;
    logic                   x_ready;
    logic [COLS*DW-1:0]     x_data = '0;
    logic                   res_valid;
    logic                   res_ready = 1'b0;
    logic [ROWS*ACC_W-1:0]  res_data;
    logic                   preload_valid;
    logic [ROW_W+COL_W-1:0] preload_addr;
    logic [DW-1:0]          preload_data;
    logic                   start;
    logic [COLS*DW-1:0]     x_vector_flat;
    logic [ROWS*ACC_W-1:0]  result_flat = '0;
    logic                   busy;
    logic                   err_len;

    int n_checks = 0;
    int n_fail   = 0;

    mesh_job_scheduler #(
        .DW(DW), .ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W), .COL_W(COL_W),
        .ACC_W(ACC_W), .CYCLE_W(CYCLE_W), .LAT_CYCLES(LAT_CYCLES)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_last(w_last),
        .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .preload_valid(preload_valid), .preload_addr(preload_addr),
        .preload_data(preload_data), .start(start),
        .x_vector_flat(x_vector_flat), .result_flat(result_flat),
        .busy(busy), .err_len(err_len)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " busy"}, busy, 0);
        check({tag, " w_ready"}, w_ready, 1);
        check({tag, " x_ready"}, x_ready, 0);
        check({tag, " preload_valid"}, preload_valid, 0);
        check({tag, " preload_addr"}, preload_addr, 0);
        check({tag, " preload_data"}, preload_data, 0);
        check({tag, " start"}, start, 0);
        check({tag, " x_vector"}, x_vector_flat, 0);
        check({tag, " res_valid"}, res_valid, 0);
        check({tag, " res_data"}, res_data, 0);
        check({tag, " err_len"}, err_len, 0);
    endtask

    // expected preload addresses {row,col} for words 0..3
    logic [2:0] exp_addr [4] = '{3'b000, 3'b001, 3'b100, 3'b101};

    initial begin
        logic [31:0] exp_res;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        #3 rst_n = 1'b1;

        // ---- load weights 1..4, w_last on the 4th word ----
        step();
        w_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w_data = DW'(i + 1);
            w_last = (i == 3);
            step();
            $display("load word %0d: addr=%0h data=%0d err=%0b", i, preload_addr, preload_data, err_len);
            check("load preload_valid", preload_valid, 1);
            check("load preload_addr", preload_addr, exp_addr[i]);
            check("load preload_data", preload_data, i + 1);
            check("load err_len", err_len, 0);
        end
        w_valid = 1'b0;
        w_last  = 1'b0;
        #1;
        check("waitx x_ready", x_ready, 1);
        check("waitx w_ready", w_ready, 0);
        check("waitx busy", busy, 1);

        // ---- first run: x = {3,5}, result_flat changes every cycle ----
        x_valid = 1'b1;
        x_data  = {8'd5, 8'd3};
        step();
        x_valid = 1'b0;
        result_flat = {16'd100, 16'd200};
        check("run1 preload idle", preload_valid, 0);
        check("run1 start", start, 1);
        check("run1 x_vector", x_vector_flat, 16'h0503);
        check("run1 x_ready", x_ready, 0);
        exp_res = {16'd104, 16'd204};
        for (int j = 1; j <= 5; j++) begin
            step();
            result_flat = {16'(100 + j), 16'(200 + j)};
            check("run1 start low", start, 0);
            check("run1 res_valid timing", res_valid, (j == 5));
        end
        check("run1 res_data", res_data, exp_res);
        $display("run1 result: %0h", res_data);

        // ---- backpressure: res_ready low for 10 cycles ----
        x_valid = 1'b1;
        x_data  = 16'hEEEE;
        for (int j = 0; j < 10; j++) begin
            step();
            result_flat = 32'($urandom);
            check("bp res_valid", res_valid, 1);
            check("bp res_data", res_data, exp_res);
            check("bp x_ready", x_ready, 0);
            check("bp w_ready", w_ready, 0);
            check("bp x_vector", x_vector_flat, 16'h0503);
        end
        x_valid   = 1'b0;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("bp drained res_valid", res_valid, 0);
        check("bp drained busy", busy, 0);

        // ---- weight reuse, res_ready held high ahead of res_valid ----
        x_valid = 1'b1;
        x_data  = 16'h0102;
        #1;
        check("reuse x_ready", x_ready, 1);
        step();
        x_valid     = 1'b0;
        res_ready   = 1'b1;
        result_flat = 32'hABCD_1234;
        check("reuse start", start, 1);
        check("reuse busy", busy, 1);
        check("reuse x_vector", x_vector_flat, 16'h0102);
        for (int j = 1; j <= 5; j++) begin
            step();
            check("reuse no preload", preload_valid, 0);
        end
        check("reuse res_valid", res_valid, 1);
        check("reuse res_data", res_data, 32'hABCD_1234);
        $display("reuse result: %0h", res_data);
        step();
        res_ready = 1'b0;
        check("reuse res_valid one cycle", res_valid, 0);
        check("reuse idle", busy, 0);

        // ---- w beats x in IDLE; w_last early on word 1, missing on word 3 ----
        x_valid = 1'b1;
        x_data  = 16'h0708;
        w_valid = 1'b1;
        #1;
        check("prio x_ready", x_ready, 0);
        check("prio w_ready", w_ready, 1);
        for (int i = 0; i < 4; i++) begin
            w_data = DW'(9 + i);
            w_last = (i == 1);
            step();
            $display("errload word %0d: addr=%0h data=%0d err=%0b", i, preload_addr, preload_data, err_len);
            check("errload start", start, 0);
            check("errload preload_addr", preload_addr, exp_addr[i]);
            check("errload preload_data", preload_data, 9 + i);
            check("errload err_len", err_len, (i == 1) || (i == 3));
        end
        w_valid = 1'b0;
        w_last  = 1'b0;
        #1;
        check("errload complete x_ready", x_ready, 1);
        step();
        x_valid = 1'b0;
        check("errload run start", start, 1);
        check("errload x_vector", x_vector_flat, 16'h0708);
        step();
        step();

        // ---- asynchronous reset in the middle of RUN ----
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrun reset");
        #2 rst_n = 1'b1;
        x_valid = 1'b1;
        x_data  = 16'h0A0B;
        #1;
        check("post reset x_ready", x_ready, 0);
        step();
        x_valid = 1'b0;
        check("post reset start", start, 0);
        check("post reset busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
